// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   localparam int unsigned WCNT_W = 4;

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with two independently writable byte lanes and a
// registered read port that can be cleared (reset or out-of-range reads).
module dmem_byte_ram #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [15:0]       wdata,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              re,
   input  logic              clr,
   output logic [15:0]       rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [7:0] lane_lo [DEPTH];
   logic [7:0] lane_hi [DEPTH];

   always_ff @(posedge clk) begin
      if (we0) lane_lo[waddr] <= wdata[7:0];
      if (we1) lane_hi[waddr] <= wdata[15:8];
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= {lane_hi[raddr], lane_lo[raddr]};
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-bus memory slave: captures a request in IDLE, waits WAIT_CYCLES,
// then pulses d_mem_rdy for one cycle with read data or a committed write.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned INIT_ZERO   = 1
) (
   input  logic        clk,
   input  logic        a_rst,
   input  logic [15:0] d_mem_addr,
   input  logic [15:0] d_mem_data_out,
   input  logic        d_mem_be0,
   input  logic        d_mem_be1,
   input  logic        d_mem_cmd,
   input  logic        d_mem_assert,
   output logic        d_mem_rdy,
   output logic [15:0] d_mem_data_in,
   output logic        d_mem_err
);

   state_t state, next_state;
   logic [WCNT_W-1:0] cnt;

   logic [ADDR_W-1:0] idx_q;
   logic [15:0]       data_q;
   logic              cmd_q, be0_q, be1_q, oor_q;

   logic [ADDR_W-1:0] req_idx, eff_idx;
   logic              req_oor, eff_oor, eff_cmd;
   logic              rdy_d, err_d, ram_re, ram_clr, commit;
   logic              unused_bits;

   assign req_idx = d_mem_addr[ADDR_W:1];
   assign req_oor = (d_mem_addr >> (ADDR_W + 1)) != '0;

   // In IDLE the live request drives the read port so a zero-wait read has data in RESP.
   assign eff_idx = (state == IDLE) ? req_idx    : idx_q;
   assign eff_oor = (state == IDLE) ? req_oor    : oor_q;
   assign eff_cmd = (state == IDLE) ? d_mem_cmd  : cmd_q;

   assign unused_bits = ^{d_mem_addr[0], (INIT_ZERO != 0)};

   always_ff @(posedge clk) begin
      if (a_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         d_mem_rdy <= 1'b0;
         d_mem_err <= 1'b0;
      end else begin
         state     <= next_state;
         d_mem_rdy <= rdy_d;
         d_mem_err <= err_d;
         if (state == IDLE) begin
            cnt <= WCNT_W'(WAIT_CYCLES);
         end else if (state == WAIT) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && d_mem_assert) begin
         idx_q  <= req_idx;
         data_q <= d_mem_data_out;
         cmd_q  <= d_mem_cmd;
         be0_q  <= d_mem_be0;
         be1_q  <= d_mem_be1;
         oor_q  <= req_oor;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (d_mem_assert) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
         end
         WAIT: begin
            if (!d_mem_assert) begin
               next_state = IDLE;
            end else if (cnt <= WCNT_W'(1)) begin
               next_state = RESP;
            end
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      rdy_d   = (next_state == RESP);
      err_d   = rdy_d && eff_oor;
      ram_re  = rdy_d && (eff_cmd == CMD_READ) && !eff_oor;
      ram_clr = rdy_d && (eff_cmd == CMD_READ) && eff_oor;
      // Reset wins over a write sitting in RESP.
      commit  = (state == RESP) && (cmd_q == CMD_WRITE) && !oor_q && !a_rst;
   end

   dmem_byte_ram #(
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk   (clk),
      .rst   (a_rst),
      .waddr (idx_q),
      .wdata (data_q),
      .we0   (commit && be0_q),
      .we1   (commit && be1_q),
      .raddr (eff_idx),
      .re    (ram_re),
      .clr   (ram_clr),
      .rdata (d_mem_data_in)
   );

endmodule
